mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 192 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq : sequential RISC-V M-extension multiply/divide unit.
//
// Purpose : computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over XLEN-bit
//           operands. Multiplies use a radix-2 shift-add loop and divides
//           use a restoring shift-subtract loop. Both work on operand
//           magnitudes, retire one bit per cycle, and fix up the sign at
//           the end. Divide-by-zero and signed overflow skip the loop.
//
// Ports   : clk     - single clock, rising edge
//           reset   - synchronous, active-high
//           start   - request a new op (only honoured in IDLE)
//           funct3  - op select (000 MUL .. 111 REMU)
//           a, b    - rs1 / rs2 operands, captured when start is accepted
//           flush   - abort the in-flight op, back to IDLE
//           busy    - unit is not IDLE
//           stall   - busy and not done; holds the pipeline
//           done    - one-cycle pulse, result valid
//           result  - product half, quotient or remainder (held until next op)
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] addend_q, addend_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            negRes_q, negRes_d;
  logic            negRem_q, negRem_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand signedness by op: divides are signed when funct3[0] is clear;
  // on the multiply side only MULHU treats a as unsigned, and only MUL/MULH
  // treat b as signed.
  logic            aSigned, bSigned, aNeg, bNeg;
  logic [XLEN-1:0] absA, absB;
  logic            divZero, divOvf;
  logic [XLEN-1:0] fastResult;

  assign aSigned = funct3[2] ? ~funct3[0] : ~(funct3[1] & funct3[0]);
  assign bSigned = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign aNeg    = aSigned & a[XLEN-1];
  assign bNeg    = bSigned & b[XLEN-1];
  assign absA    = aNeg ? -a : a;
  assign absB    = bNeg ? -b : b;

  // Divide corner cases resolve without iterating.
  assign divZero    = funct3[2] && (b == '0);
  assign divOvf     = funct3[2] && !funct3[0] &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign fastResult = divZero ? (funct3[1] ? a  : '1)
                              : (funct3[1] ? '0 : a);

  // One iteration step for each algorithm. {hi_q, lo_q} is the 2*XLEN
  // product register for multiplies. For divides, hi_q holds the partial
  // remainder and lo_q shifts the dividend out while the quotient shifts in.
  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] prodRaw, prodFix;
  logic [XLEN-1:0]   quotFix, remFix, fixResult;

  assign mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
  assign divShift = {hi_q, lo_q[XLEN-1]};
  assign divDiff  = divShift - {1'b0, addend_q};

  assign prodRaw   = {hi_q, lo_q};
  assign prodFix   = negRes_q ? -prodRaw : prodRaw;
  assign quotFix   = negRes_q ? -lo_q : lo_q;
  assign remFix    = negRem_q ? -hi_q : hi_q;
  assign fixResult = op_q[2] ? (op_q[1] ? remFix : quotFix)
                             : ((op_q[1:0] == 2'b00) ? prodFix[XLEN-1:0]
                                                      : prodFix[2*XLEN-1:XLEN]);

  // Next-state and output decode. flush wins over everything except reset,
  // and it also blocks the result update, so an aborted op leaves result
  // untouched.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addend_d = addend_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    result_d = result_q;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    stall    = busy & ~done;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_d     = funct3;
            negRes_d = aNeg ^ bNeg;
            negRem_d = aNeg;
            cnt_d    = '0;
            if (divZero || divOvf) begin
              result_d = fastResult;
              state_d  = DONE;
            end else begin
              // The addend is the multiplicand or the divisor. lo starts
              // with the multiplier or the dividend.
              addend_d = funct3[2] ? absB : absA;
              lo_d     = funct3[2] ? absA : absB;
              hi_d     = '0;
              state_d  = ITER;
            end
          end
        end
        ITER: begin
          if (op_q[2]) begin
            if (!divDiff[XLEN]) begin
              hi_d = divDiff[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = divShift[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = mulSum[XLEN:1];
            lo_d = {mulSum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == CW'(XLEN-1)) begin
            cnt_d   = '0;
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        FIX: begin
          result_d = fixResult;
          state_d  = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers. reset takes priority over flush and start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      addend_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addend_q <= addend_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq : self-checking bench for mdu_seq (XLEN = 32).
//
// Each accepted op pushes its expected result onto a scoreboard queue, and
// the entry is popped when done pulses. Latency counts the edge that
// samples start as edge 1, so a normal op finishes at edge 34 and a fast
// path finishes at edge 1.
module tb_mdu_seq;

  localparam int XLEN  = 32;
  localparam int LIMIT = 60;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] result;

  int          nCompared   = 0;
  int          nMismatched = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastExp;

  mdu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .a(a), .b(b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Independent RISC-V reference built from 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sp;
    longint unsigned ux, uy, up;
    logic            ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = ux * uy; return up[31:0]; end
      3'd1: begin sp = sx * sy; return sp[63:32]; end
      3'd2: begin sp = sx * longint'(uy); return sp[63:32]; end
      3'd3: begin up = ux * uy; return up[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        sp = sx / sy; return sp[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        sp = sx % sy; return sp[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Drive a start for one edge, then scramble the operand inputs.
  task automatic drive(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    funct3 = f; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
  endtask

  // Wait for done and report its edge number. Operand inputs keep moving
  // the whole time.
  task automatic waitDone(output int edges, output bit got, output int stallLow);
    edges = 1; got = 1'b0; stallLow = 0;
    while (edges < LIMIT) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      if (stall !== 1'b1) stallLow++;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic runOp(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, output bit got, output int edges, output int stallLow);
    expQ.push_back(e);
    drive(f, x, y);
    waitDone(edges, got, stallLow);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'd0; a = 32'd9; b = 32'd9;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    nCompared++; if (stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    nCompared++; if (result !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_result got=%h exp=0", result); end
    reset = 1'b0;
    lastExp = 32'h0;
  endtask

  task automatic test_mul();
    bit got; int edges, stallLow; logic [31:0] e;
    runOp(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, got, edges, stallLow);
    e = expQ.pop_front();
    nCompared++; if (!got || result !== e) begin nMismatched++; $display("[TB] FAIL mul_result got=%h done=%b exp=%h", result, got, e); end
    nCompared++; if (edges != 34) begin nMismatched++; $display("[TB] FAIL mul_latency got=%0d exp=34", edges); end
    nCompared++; if (stallLow != 0) begin nMismatched++; $display("[TB] FAIL mul_stall low_cycles=%0d exp=0", stallLow); end
    @(posedge clk); #1;
    nCompared++; if (done !== 1'b0 || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL mul_done_pulse done=%b busy=%b exp=0/0", done, busy); end
    repeat (3) @(posedge clk);
    #1;
    nCompared++; if (result !== e) begin nMismatched++; $display("[TB] FAIL mul_hold got=%h exp=%h", result, e); end
    lastExp = e;
  endtask

  task automatic test_mulh();
    bit got; int edges, stallLow; logic [31:0] e;
    vec_t v[3];
    v[0] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    v[1] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    v[2] = '{3'd2, 32'hFFFF_FFFF, 32'd2, refModel(3'd2, 32'hFFFF_FFFF, 32'd2), 34};
    for (int i = 0; i < 3; i++) begin
      runOp(v[i].f, v[i].x, v[i].y, v[i].e, got, edges, stallLow);
      e = expQ.pop_front();
      nCompared++; if (!got || result !== e) begin nMismatched++; $display("[TB] FAIL mulh_result[%0d] got=%h done=%b exp=%h", i, result, got, e); end
      nCompared++; if (edges != v[i].lat) begin nMismatched++; $display("[TB] FAIL mulh_latency[%0d] got=%0d exp=%0d", i, edges, v[i].lat); end
      @(posedge clk); #1;
      lastExp = e;
    end
  endtask

  task automatic test_div();
    bit got; int edges, stallLow; logic [31:0] e;
    vec_t v[4];
    v[0] = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34};
    v[1] = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34};
    v[2] = '{3'd5, 32'd100, 32'd7, 32'd14, 34};
    v[3] = '{3'd7, 32'd100, 32'd7, 32'd2, 34};
    for (int i = 0; i < 4; i++) begin
      runOp(v[i].f, v[i].x, v[i].y, v[i].e, got, edges, stallLow);
      e = expQ.pop_front();
      nCompared++; if (!got || result !== e) begin nMismatched++; $display("[TB] FAIL div_result[%0d] got=%h done=%b exp=%h", i, result, got, e); end
      nCompared++; if (edges != v[i].lat) begin nMismatched++; $display("[TB] FAIL div_latency[%0d] got=%0d exp=%0d", i, edges, v[i].lat); end
      @(posedge clk); #1;
      lastExp = e;
    end
  endtask

  task automatic test_fastpath();
    bit got; int edges, stallLow; logic [31:0] e;
    vec_t v[6];
    v[0] = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    v[1] = '{3'd7, 32'd5, 32'd0, 32'd5, 1};
    v[2] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[3] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1};
    v[4] = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    v[5] = '{3'd6, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFD, 1};
    for (int i = 0; i < 6; i++) begin
      runOp(v[i].f, v[i].x, v[i].y, v[i].e, got, edges, stallLow);
      e = expQ.pop_front();
      nCompared++; if (!got || result !== e) begin nMismatched++; $display("[TB] FAIL fast_result[%0d] got=%h done=%b exp=%h", i, result, got, e); end
      nCompared++; if (edges != v[i].lat) begin nMismatched++; $display("[TB] FAIL fast_latency[%0d] got=%0d exp=%0d", i, edges, v[i].lat); end
      @(posedge clk); #1;
      nCompared++; if (done !== 1'b0 || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL fast_done_pulse[%0d] done=%b busy=%b exp=0/0", i, done, busy); end
      lastExp = e;
    end
  endtask

  task automatic test_random();
    bit got; int edges, stallLow, lat; logic [31:0] e, x, y; logic [2:0] f;
    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      lat = (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) ? 1 : 34;
      runOp(f, x, y, refModel(f, x, y), got, edges, stallLow);
      e = expQ.pop_front();
      nCompared++; if (!got || result !== e) begin nMismatched++; $display("[TB] FAIL rand_result[%0d] f=%0d a=%h b=%h got=%h exp=%h", i, f, x, y, result, e); end
      nCompared++; if (edges != lat) begin nMismatched++; $display("[TB] FAIL rand_latency[%0d] got=%0d exp=%0d", i, edges, lat); end
      @(posedge clk); #1;
      lastExp = e;
    end
  endtask

  task automatic test_flush();
    bit got; int edges, stallLow; logic [31:0] e;
    drive(3'd5, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    nCompared++; if (busy !== 1'b0 || done !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_idle busy=%b done=%b exp=0/0", busy, done); end
    nCompared++; if (result !== lastExp) begin nMismatched++; $display("[TB] FAIL flush_result got=%h exp=%h", result, lastExp); end
    runOp(3'd5, 32'd100, 32'd7, 32'd14, got, edges, stallLow);
    e = expQ.pop_front();
    nCompared++; if (!got || result !== e) begin nMismatched++; $display("[TB] FAIL flush_restart_result got=%h done=%b exp=%h", result, got, e); end
    nCompared++; if (edges != 34) begin nMismatched++; $display("[TB] FAIL flush_restart_latency got=%0d exp=34", edges); end
    @(posedge clk); #1;
    lastExp = e;
    // flush and start together in IDLE: the start must be dropped
    funct3 = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_start_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int nDone, doneEdge; logic busyAt35; logic [31:0] e;
    nDone = 0; doneEdge = 0; busyAt35 = 1'bx;
    expQ.push_back(32'hFFFF_FFFD);
    drive(3'd4, 32'hFFFF_FFF9, 32'd2);
    for (int ed = 2; ed <= 40; ed++) begin
      start = (ed == 6 || ed == 20 || ed == 35);
      if (start) begin funct3 = 3'd0; a = 32'd3; b = 32'd3; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin nDone++; doneEdge = ed; end
      if (ed == 35) busyAt35 = busy;
    end
    e = expQ.pop_front();
    nCompared++; if (nDone != 1) begin nMismatched++; $display("[TB] FAIL b2b_done_count got=%0d exp=1", nDone); end
    nCompared++; if (doneEdge != 34) begin nMismatched++; $display("[TB] FAIL b2b_done_edge got=%0d exp=34", doneEdge); end
    nCompared++; if (result !== e) begin nMismatched++; $display("[TB] FAIL b2b_result got=%h exp=%h", result, e); end
    nCompared++; if (busyAt35 !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_start_in_done busy=%b exp=0", busyAt35); end
    lastExp = e;
  endtask

  task automatic test_reset_mid();
    int nDone;
    nDone = 0;
    drive(3'd0, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1; flush = 1'b1; start = 1'b1; funct3 = 3'd0;
    @(posedge clk); #1;
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
    nCompared++; if (stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_stall got=%b exp=0", stall); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_done got=%b exp=0", done); end
    nCompared++; if (result !== 32'h0) begin nMismatched++; $display("[TB] FAIL rstmid_result got=%h exp=0", result); end
    reset = 1'b0; flush = 1'b0; start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) nDone++;
    end
    nCompared++; if (nDone != 0) begin nMismatched++; $display("[TB] FAIL rstmid_no_done got=%0d exp=0", nDone); end
    lastExp = 32'h0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fastpath();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    nCompared++; if (expQ.size() != 0) begin nMismatched++; $display("[TB] FAIL scoreboard_left got=%0d exp=0", expQ.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
